// File: rtl/multiplier_seq_32bit.sv
// Sequential 32x32 -> 64-bit shift-add multiplier with per-operand signedness.
// One radix-2 iteration per clock on operand magnitudes, fixed 32 iterations,
// sign applied once at the end.
//
// Result handshake: o_valid rises when o_prod holds a new product and stays
// high, with o_prod stable, until a rising edge where i_ready=1; that edge
// consumes the result and returns the block to IDLE. i_start is only looked
// at in IDLE, so a start presented on the consuming edge is not taken.
module multiplier_seq_32bit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_a_signed,
  input  logic        i_b_signed,
  input  logic        i_ready,
  output logic [63:0] o_prod,
  output logic        o_valid,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;   // multiplicand magnitude, shifted left each iteration
  logic [31:0] mplier_q, mplier_d; // multiplier magnitude, shifted right each iteration
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [63:0] prod_q, prod_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  // Operand conditioning: negative signed operands become their magnitude.
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc_sum;
  logic [63:0] final_prod;

  assign a_neg      = i_a_signed & i_a[31];
  assign b_neg      = i_b_signed & i_b[31];
  assign a_mag      = a_neg ? (32'd0 - i_a) : i_a;
  assign b_mag      = b_neg ? (32'd0 - i_b) : i_b;
  assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign final_prod = sign_q ? (64'd0 - acc_sum) : acc_sum;

  // Next-state and datapath update for IDLE / BUSY / DONE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    prod_d   = prod_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mcand_d  = {32'd0, a_mag};
          mplier_d = b_mag;
          sign_d   = a_neg ^ b_neg;
          acc_d    = 64'd0;
          cnt_d    = 5'd0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        // The 32nd iteration folds straight into the output register.
        if (cnt_q == 5'd31) begin
          prod_d  = final_prod;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      sign_q   <= 1'b0;
      prod_q   <= 64'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      prod_q   <= prod_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign o_prod      = prod_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_multiplier_seq_32bit.sv
// Bench for multiplier_seq_32bit: directed corners, backpressure, reset
// abort, back-to-back and randomized operations against a product model.
module tb_multiplier_seq_32bit;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_a_signed;
  logic        i_b_signed;
  logic        i_ready;
  logic [63:0] o_prod;
  logic        o_valid;
  logic        o_busy;
  logic [1:0]  o_dbg_state;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  multiplier_seq_32bit dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_a_signed  (i_a_signed),
    .i_b_signed  (i_b_signed),
    .i_ready     (i_ready),
    .o_prod      (o_prod),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------- helpers ----------------
  function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic as, input logic bs);
    logic [63:0] ax, bx;
    ax = as ? {{32{a[31]}}, a} : {32'd0, a};
    bx = bs ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks what the outputs must be from the transaction rules: a start in
  // idle begins a 32-cycle operation, the result appears and waits for ready.
  logic [63:0] exp_q[$];
  logic [63:0] m_prod  = 64'd0;
  logic [63:0] m_pend  = 64'd0;
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  int          m_cyc   = 0;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_prod  = 64'd0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_cyc   = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (i_start) begin
        m_pend = golden(i_a, i_b, i_a_signed, i_b_signed);
        m_busy = 1'b1;
        m_cyc  = 0;
      end
    end else if (!m_valid) begin
      m_cyc++;
      if (m_cyc == 32) begin
        m_prod  = m_pend;
        m_valid = 1'b1;
        exp_q.push_back(m_pend);
      end
    end else if (i_ready) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge i_clk) begin
    if (chk_en && !i_reset) begin
      check64("busy_vs_model",  {63'd0, o_busy},  {63'd0, m_busy});
      check64("valid_vs_model", {63'd0, o_valid}, {63'd0, m_valid});
      check64("prod_vs_model",  o_prod, m_prod);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check64("handoff_without_expected", {63'd0, o_valid}, 64'd0);
        end else begin
          check64("handoff_prod", o_prod, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Run one operation from IDLE; check latency, product, stall hold and handoff.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic as, input logic bs, input logic [63:0] exp,
                       input int stall, input bit scramble);
    int lat;
    i_a = a; i_b = b; i_a_signed = as; i_b_signed = bs;
    i_ready = 1'b0;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      if (scramble) begin
        i_start    = 1'($urandom_range(0, 1));
        i_a        = $urandom;
        i_b        = $urandom;
        i_a_signed = 1'($urandom_range(0, 1));
        i_b_signed = 1'($urandom_range(0, 1));
      end
      @(posedge i_clk); #1;
      lat++;
    end
    check64("latency", 64'(lat), 64'd32);
    check64("result", o_prod, exp);
    for (int s = 0; s < stall; s++) begin
      i_start = 1'b1;
      i_a     = $urandom;
      i_b     = $urandom;
      @(posedge i_clk); #1;
      check64("stall_valid", {63'd0, o_valid}, 64'd1);
      check64("stall_prod",  o_prod, exp);
      check64("stall_busy",  {63'd0, o_busy}, 64'd1);
    end
    i_ready = 1'b1;
    i_start = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    i_start = 1'b0;
    check64("after_handoff_busy",  {63'd0, o_busy}, 64'd0);
    check64("after_handoff_valid", {63'd0, o_valid}, 64'd0);
    check64("after_handoff_prod",  o_prod, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int last_rise;
    int cyc;
    int rises;
    logic prev_valid;
    logic [31:0] ra, rb;
    logic ras, rbs;

    i_reset = 1'b0; i_start = 1'b0; i_a = 32'd0; i_b = 32'd0;
    i_a_signed = 1'b0; i_b_signed = 1'b0; i_ready = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    check64("reset_prod",  o_prod, 64'd0);
    check64("reset_valid", {63'd0, o_valid}, 64'd0);
    check64("reset_busy",  {63'd0, o_busy}, 64'd0);
    #18 i_reset = 1'b0;
    chk_en = 1'b1;
    @(posedge i_clk); #1;

    // Model pins against hand-computed products.
    check64("pin_umax",  golden(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0), 64'hFFFFFFFE00000001);
    check64("pin_m1m1",  golden(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1), 64'h0000000000000001);
    check64("pin_minmin", golden(32'h80000000, 32'h80000000, 1'b1, 1'b1), 64'h4000000000000000);
    check64("pin_mixed", golden(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0), 64'hFFFFFFFF00000001);

    // Directed corners.
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, 0, 1'b0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001, 0, 1'b0);
    do_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, 0, 1'b0);
    do_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFF80000000, 0, 1'b0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001, 0, 1'b0);
    do_op(32'h00000000, 32'h80000000, 1'b1, 1'b1, 64'h0000000000000000, 0, 1'b0);

    // Backpressure: five stalled cycles with start pulses and operand changes.
    do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1,
          golden(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1), 5, 1'b1);

    // Reset ten cycles into an operation, then a clean 7*6.
    i_a = 32'hDEADBEEF; i_b = 32'h00C0FFEE; i_a_signed = 1'b1; i_b_signed = 1'b0;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1 i_reset = 1'b1;
    #1;
    check64("midop_reset_prod",  o_prod, 64'd0);
    check64("midop_reset_valid", {63'd0, o_valid}, 64'd0);
    check64("midop_reset_busy",  {63'd0, o_busy}, 64'd0);
    @(posedge i_clk); #1 i_reset = 1'b0;
    @(posedge i_clk); #1;
    do_op(32'd7, 32'd6, 1'b0, 1'b0, 64'h000000000000002A, 0, 1'b0);

    // Back-to-back: start and ready held high, one result every 34 cycles.
    i_ready = 1'b1;
    i_start = 1'b1;
    last_rise = -1;
    rises = 0;
    prev_valid = 1'b0;
    for (cyc = 0; cyc < 34 * 4 + 4; cyc++) begin
      i_a        = $urandom;
      i_b        = $urandom;
      i_a_signed = 1'($urandom_range(0, 1));
      i_b_signed = 1'($urandom_range(0, 1));
      @(posedge i_clk); #1;
      if (o_valid && !prev_valid) begin
        if (last_rise >= 0) check64("b2b_period", 64'(cyc - last_rise), 64'd34);
        last_rise = cyc;
        rises++;
      end
      prev_valid = o_valid;
    end
    check64("b2b_results", 64'(rises), 64'd4);
    i_start = 1'b0;
    cyc = 0;
    while (o_busy && cyc < 40) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    check64("b2b_drain_idle", {63'd0, o_busy}, 64'd0);
    i_ready = 1'b0;

    // Randomized operations with noise on inputs while busy.
    for (int n = 0; n < 30; n++) begin
      ra  = pick_operand();
      rb  = pick_operand();
      ras = 1'($urandom_range(0, 1));
      rbs = 1'($urandom_range(0, 1));
      do_op(ra, rb, ras, rbs, golden(ra, rb, ras, rbs), $urandom_range(0, 3), 1'b1);
    end

    @(posedge i_clk); #1;
    check64("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_seq_32bit.md
MULTIPLIER_SEQ_32BIT -- requirements
Module: multiplier_seq_32bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named i_clk and i_reset.
REQ-002 The block SHALL have no parameters; operand width is fixed at 32 bits and product width at 64 bits.
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_start  input  1  request to start a multiply; sampled only in IDLE.
REQ-006 i_a  input  32  multiplicand.
REQ-007 i_b  input  32  multiplier.
REQ-008 i_a_signed  input  1  1 = i_a is two's complement; 0 = unsigned.
REQ-009 i_b_signed  input  1  1 = i_b is two's complement; 0 = unsigned.
REQ-010 i_ready  input  1  consumer accepts the result when o_valid=1.
REQ-011 o_prod  output  64  full product, mod 2^64, two's complement if either operand is signed.
REQ-012 o_valid  output  1  o_prod is valid; held until accepted.
REQ-013 o_busy  output  1  high in BUSY and DONE; new requests are not accepted.

Function
REQ-014 States SHALL be IDLE, BUSY and DONE.
REQ-015 Acceptance: at an edge k in IDLE with i_start=1, the block SHALL latch the operand magnitudes, the result sign and the signedness controls; clear the accumulator and the 5-bit iteration counter; and go to BUSY.
REQ-016 Magnitude: for a signed operand with bit31=1, the latched magnitude SHALL be its 32-bit two's complement negation, treated as unsigned, so that 0x80000000 gives magnitude 0x80000000.
REQ-017 Result sign SHALL be (i_a_signed & i_a[31]) XOR (i_b_signed & i_b[31]).
REQ-018 In BUSY, each edge SHALL perform one shift-add iteration on the magnitudes: if the current multiplier bit is 1, add the shifted multiplicand into the 64-bit accumulator; advance one bit; increment the counter.
REQ-019 The iteration count SHALL be fixed at 32 for all operand values, including zero; there is no early termination.
REQ-020 At edge k+32 (the 32nd iteration), the block SHALL load o_prod with the final accumulator, negated mod 2^64 if the result sign is 1, set o_valid=1 and go to DONE.
REQ-021 Latency from the acceptance edge to o_valid high SHALL be exactly 32 cycles.
REQ-022 In DONE, o_valid and o_prod SHALL hold stable while i_ready=0.
REQ-023 At an edge in DONE with i_ready=1, the block SHALL clear o_valid and return to IDLE.
REQ-024 An i_start sampled at that same edge SHALL be ignored; the next acceptance is possible no earlier than the following edge.
REQ-025 i_start in BUSY or DONE SHALL be ignored, with no effect on the operation in progress.
REQ-026 Operand changes after acceptance SHALL NOT affect the result.
REQ-027 o_prod SHALL retain the last result in IDLE until the next result is loaded.
REQ-028 o_busy SHALL be 1 exactly when the state is BUSY or DONE.
REQ-029 Negating a zero magnitude SHALL yield 0; a signed zero product is all zeros.

Reset
REQ-030 When i_reset=1, asynchronously and regardless of state, the block SHALL go to IDLE with o_prod=0, o_valid=0, o_busy=0, and clear the accumulator, counter and latched operands.
REQ-031 Reset mid-operation SHALL abort the operation with no result produced.
REQ-032 The first i_start after reset is released SHALL be accepted normally.

Verification
REQ-033 Unsigned max: a=b=0xFFFFFFFF, both unsigned -> o_valid exactly 32 cycles after acceptance, o_prod=0xFFFFFFFE00000001.
REQ-034 Signed corners: -1*-1 signed -> 0x0000000000000001; 0x80000000*0x80000000 signed -> 0x4000000000000000; 0x80000000 signed * 1 signed -> 0xFFFFFFFF80000000.
REQ-035 Mixed signedness: a=0xFFFFFFFF signed, b=0xFFFFFFFF unsigned -> 0xFFFFFFFF00000001; a=0 signed, b=0x80000000 signed -> 0x0000000000000000 after 32 cycles.
REQ-036 Backpressure: hold i_ready=0 for 5 cycles in DONE, pulse i_start and change i_a/i_b -> o_valid and o_prod stable, o_busy=1, no new acceptance; then i_ready=1 -> IDLE the next cycle.
REQ-037 Reset mid-op: assert i_reset 10 cycles after acceptance -> o_prod=0, o_valid=0, o_busy=0 immediately; a subsequent 7*6 unsigned -> 0x000000000000002A at 32-cycle latency.
REQ-038 Back-to-back: i_start held high continuously with i_ready=1 -> one result per 34 cycles (accept, 32 iterations, handoff), each matching the golden model.
